// File: rtl/vid_fetch_sequencer.sv
// Video fetch sequencer: burst-reads framebuffer lines into a pixel FIFO and streams them as AXI4-Stream video.
// Define VID_FETCH_SEQUENCER_DBG_EN to add the dbg_x/dbg_y/dbg_state/dbg_pixcount observation ports.

module vid_fetch_sequencer #(
   parameter int FIFO_DEPTH = 32,
   parameter int BURST_LEN  = 8
) (
   input  logic        m_axis_vid_aclk,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] cfg_base,
   input  logic [15:0] cfg_pitch,
   input  logic [11:0] cfg_width,
   input  logic [11:0] cfg_height,
   output logic        rd_req,
   output logic [31:0] rd_addr,
   output logic [7:0]  rd_len,
   input  logic        rd_ack,
   input  logic        rd_data_valid,
   input  logic [31:0] rd_data,
   output logic [31:0] s_axis_vid_tdata,
   output logic        s_axis_vid_tvalid,
   input  logic        s_axis_vid_tready,
   output logic        s_axis_vid_tuser,
   output logic        s_axis_vid_tlast,
   output logic        busy,
   output logic        underflow
`ifdef VID_FETCH_SEQUENCER_DBG_EN
   ,
   output logic [15:0] dbg_x,
   output logic [15:0] dbg_y,
   output logic [2:0]  dbg_state,
   output logic [15:0] dbg_pixcount
`endif
);

   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 1;
   localparam int CW1 = CW + 1;
   localparam logic [CW1-1:0] DEPTH_C = CW1'(FIFO_DEPTH);
   localparam logic [CW1-1:0] BURST_C = CW1'(BURST_LEN);
   localparam logic [11:0]    BURST_X = 12'(BURST_LEN);
   localparam logic [CW-1:0]  FULL_C  = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;
   state_t state, state_nxt;

   logic [31:0]   line_base;
   logic [15:0]   pitch_q;
   logic [11:0]   width_q, height_q, fetched_x, fetch_y, out_x, out_y;
   logic [CW-1:0] fifo_count, outstanding;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [31:0]   fifo_mem [FIFO_DEPTH];

   logic          cfg_ok, space_ok, accept, line_done, fetch_done;
   logic          push, pop, last_x, last_y, frame_end, start;
   logic [11:0]   remaining, burst;

   assign cfg_ok     = enable && (cfg_width != 12'd0) && (cfg_height != 12'd0);
   // Outstanding beats already own FIFO slots, so they count against free space.
   assign space_ok   = ({1'b0, fifo_count} + {1'b0, outstanding} + BURST_C) <= DEPTH_C;
   assign remaining  = width_q - fetched_x;
   assign burst      = (remaining > BURST_X) ? BURST_X : remaining;
   assign accept     = rd_req && rd_ack;
   assign line_done  = ({1'b0, fetched_x} + {1'b0, burst}) == {1'b0, width_q};
   assign fetch_done = line_done && (fetch_y == height_q - 12'd1);
   assign push       = rd_data_valid && (outstanding != '0) && (fifo_count != FULL_C);
   assign pop        = s_axis_vid_tvalid && s_axis_vid_tready;
   assign last_x     = (out_x == width_q - 12'd1);
   assign last_y     = (out_y == height_q - 12'd1);
   assign frame_end  = pop && last_x && last_y;
   assign start      = cfg_ok && ((state == IDLE) || ((state == DRAIN) && frame_end));

   always_comb begin
      state_nxt = state;
      rd_req    = 1'b0;
      case (state)
         IDLE:    if (cfg_ok) state_nxt = space_ok ? REQ : WAIT;
         REQ: begin
            rd_req = 1'b1;
            if (rd_ack) state_nxt = fetch_done ? DRAIN : WAIT;
         end
         WAIT:    if (space_ok) state_nxt = REQ;
         DRAIN:   if (frame_end) state_nxt = cfg_ok ? REQ : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign rd_addr           = rd_req ? (line_base + {18'b0, fetched_x, 2'b00}) : 32'd0;
   assign rd_len            = rd_req ? burst[7:0] : 8'd0;
   assign busy              = (state != IDLE);
   assign s_axis_vid_tvalid = (fifo_count != '0);
   assign s_axis_vid_tdata  = fifo_mem[rd_ptr];
   assign s_axis_vid_tuser  = s_axis_vid_tvalid && (out_x == 12'd0) && (out_y == 12'd0);
   assign s_axis_vid_tlast  = s_axis_vid_tvalid && last_x;

   always_ff @(posedge m_axis_vid_aclk) begin
      if (push) fifo_mem[wr_ptr] <= rd_data;
   end

   always_ff @(posedge m_axis_vid_aclk) begin
      if (reset) begin
         state       <= IDLE;
         line_base   <= 32'd0;
         pitch_q     <= 16'd0;
         width_q     <= 12'd0;
         height_q    <= 12'd0;
         fetched_x   <= 12'd0;
         fetch_y     <= 12'd0;
         out_x       <= 12'd0;
         out_y       <= 12'd0;
         outstanding <= '0;
         fifo_count  <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         underflow   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (start) begin
            line_base <= cfg_base;
            pitch_q   <= cfg_pitch;
            width_q   <= cfg_width;
            height_q  <= cfg_height;
            fetched_x <= 12'd0;
            fetch_y   <= 12'd0;
         end else if (accept) begin
            if (line_done) begin
               fetched_x <= 12'd0;
               line_base <= line_base + {16'b0, pitch_q};
               fetch_y   <= fetch_y + 12'd1;
            end else begin
               fetched_x <= fetched_x + burst;
            end
         end
         outstanding <= outstanding + (accept ? CW'(burst) : '0) - (push ? CW'(1) : '0);
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      fifo_count <= fifo_count + CW'(1);
         else if (pop && !push) fifo_count <= fifo_count - CW'(1);
         if (pop) begin
            if (last_x) begin
               out_x <= 12'd0;
               out_y <= last_y ? 12'd0 : out_y + 12'd1;
            end else begin
               out_x <= out_x + 12'd1;
            end
         end
         // Starved mid-line while data is still owed by memory.
         if (busy && (fifo_count == '0) && (out_x != 12'd0) && (out_x < width_q) && (outstanding != '0))
            underflow <= 1'b1;
      end
   end

`ifdef VID_FETCH_SEQUENCER_DBG_EN
   logic [15:0] pixcount;

   always_ff @(posedge m_axis_vid_aclk) begin
      if (reset)     pixcount <= 16'd0;
      else if (pop)  pixcount <= s_axis_vid_tlast ? 16'd0 : pixcount + 16'd1;
   end

   assign dbg_x        = {4'b0, out_x};
   assign dbg_y        = {4'b0, out_y};
   assign dbg_state    = {1'b0, state};
   assign dbg_pixcount = pixcount;
`endif

endmodule

// File: tb/tb_vid_fetch_sequencer.sv
// Self-checking bench for vid_fetch_sequencer: table of frame configurations plus hand-written corner sequences,
// with a scoreboard of expected requests and pixels built from each frame's configuration.

module tb_vid_fetch_sequencer;

   localparam int BURST = 8;

   logic        m_axis_vid_aclk = 1'b0;
   logic        reset;
   logic        enable;
   logic [31:0] cfg_base;
   logic [15:0] cfg_pitch;
   logic [11:0] cfg_width;
   logic [11:0] cfg_height;
   logic        rd_req;
   logic [31:0] rd_addr;
   logic [7:0]  rd_len;
   logic        rd_ack;
   logic        rd_data_valid;
   logic [31:0] rd_data;
   logic [31:0] s_axis_vid_tdata;
   logic        s_axis_vid_tvalid;
   logic        s_axis_vid_tready;
   logic        s_axis_vid_tuser;
   logic        s_axis_vid_tlast;
   logic        busy;
   logic        underflow;

   vid_fetch_sequencer #(.FIFO_DEPTH(32), .BURST_LEN(BURST)) dut (
      .m_axis_vid_aclk   (m_axis_vid_aclk),
      .reset             (reset),
      .enable            (enable),
      .cfg_base          (cfg_base),
      .cfg_pitch         (cfg_pitch),
      .cfg_width         (cfg_width),
      .cfg_height        (cfg_height),
      .rd_req            (rd_req),
      .rd_addr           (rd_addr),
      .rd_len            (rd_len),
      .rd_ack            (rd_ack),
      .rd_data_valid     (rd_data_valid),
      .rd_data           (rd_data),
      .s_axis_vid_tdata  (s_axis_vid_tdata),
      .s_axis_vid_tvalid (s_axis_vid_tvalid),
      .s_axis_vid_tready (s_axis_vid_tready),
      .s_axis_vid_tuser  (s_axis_vid_tuser),
      .s_axis_vid_tlast  (s_axis_vid_tlast),
      .busy              (busy),
      .underflow         (underflow)
   );

   always #5 m_axis_vid_aclk = ~m_axis_vid_aclk;

   typedef struct {
      logic [31:0] data;
      logic        user;
      logic        last;
   } beat_t;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
   } req_t;

   typedef struct {
      logic [11:0] width;
      logic [11:0] height;
      logic [31:0] base;
      logic [15:0] pitch;
      int          tready_mode;
      int          exp_beats;
      int          exp_reqs;
   } vec_t;

   vec_t        vecs[6];
   beat_t       exp_q[$];
   req_t        req_q[$];
   logic [31:0] mem_q[$];

   int   checks = 0;
   int   errors = 0;
   int   beats_seen, reqs_seen, beats_delivered;
   int   tready_mode;
   bit   ack_en, mem_en, tog;
   bit   prev_stall;
   logic [31:0] prev_data;
   logic        prev_user, prev_last;

   function automatic logic [31:0] pix(input logic [31:0] a);
      return a ^ 32'hA5C3_0F00;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
      end
   endtask

   // One clock of memory model, request port and sink; outputs are sampled 1 time unit after the edge.
   task automatic applyStimulus();
      req_t  r;
      beat_t b;
      if (mem_en && mem_q.size() > 0) begin
         rd_data_valid = 1'b1;
         rd_data       = pix(mem_q.pop_front());
         beats_delivered++;
      end else begin
         rd_data_valid = 1'b0;
      end
      rd_ack = ack_en;
      if (rd_req && rd_ack) begin
         reqs_seen++;
         if (req_q.size() == 0) begin
            checkOutput("unexpected_req", rd_addr, 32'hFFFF_FFFF);
         end else begin
            r = req_q.pop_front();
            checkOutput("req_addr", rd_addr, r.addr);
            checkOutput("req_len", 32'(rd_len), 32'(r.len));
         end
         for (int i = 0; i < int'(rd_len); i++) mem_q.push_back(rd_addr + 32'(4 * i));
      end
      case (tready_mode)
         0:       s_axis_vid_tready = 1'b1;
         1: begin s_axis_vid_tready = tog; tog = ~tog; end
         default: s_axis_vid_tready = 1'b0;
      endcase
      if (prev_stall) begin
         checkOutput("hold_valid", 32'(s_axis_vid_tvalid), 32'd1);
         checkOutput("hold_data", s_axis_vid_tdata, prev_data);
         checkOutput("hold_user", 32'(s_axis_vid_tuser), 32'(prev_user));
         checkOutput("hold_last", 32'(s_axis_vid_tlast), 32'(prev_last));
      end
      if (s_axis_vid_tvalid && s_axis_vid_tready) begin
         beats_seen++;
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_beat", s_axis_vid_tdata, 32'hFFFF_FFFF);
         end else begin
            b = exp_q.pop_front();
            checkOutput("tdata", s_axis_vid_tdata, b.data);
            checkOutput("tuser", 32'(s_axis_vid_tuser), 32'(b.user));
            checkOutput("tlast", 32'(s_axis_vid_tlast), 32'(b.last));
         end
      end
      prev_stall = s_axis_vid_tvalid && !s_axis_vid_tready;
      prev_data  = s_axis_vid_tdata;
      prev_user  = s_axis_vid_tuser;
      prev_last  = s_axis_vid_tlast;
      @(posedge m_axis_vid_aclk);
      #1;
   endtask

   task automatic startFrame(input logic [11:0] w, input logic [11:0] h,
                             input logic [31:0] base, input logic [15:0] pitch);
      logic [31:0] lb;
      req_t        r;
      beat_t       b;
      cfg_width  = w;
      cfg_height = h;
      cfg_base   = base;
      cfg_pitch  = pitch;
      beats_seen = 0;
      reqs_seen  = 0;
      beats_delivered = 0;
      for (int y = 0; y < int'(h); y++) begin
         lb = base + 32'(y) * {16'b0, pitch};
         for (int x = 0; x < int'(w); x += BURST) begin
            r.addr = lb + 32'(4 * x);
            r.len  = 8'((int'(w) - x > BURST) ? BURST : int'(w) - x);
            req_q.push_back(r);
         end
         for (int x = 0; x < int'(w); x++) begin
            b.data = pix(lb + 32'(4 * x));
            b.user = (x == 0) && (y == 0);
            b.last = (x == int'(w) - 1);
            exp_q.push_back(b);
         end
      end
   endtask

   task automatic waitIdle(input string name);
      int n = 0;
      while (busy && n < 3000) begin
         applyStimulus();
         n++;
      end
      if (n >= 3000) checkOutput(name, 32'(busy), 32'd0);
   endtask

   task automatic runFrame(input int idx);
      tready_mode = vecs[idx].tready_mode;
      startFrame(vecs[idx].width, vecs[idx].height, vecs[idx].base, vecs[idx].pitch);
      enable = 1'b1;
      applyStimulus();
      checkOutput("busy_start", 32'(busy), 32'd1);
      enable = 1'b0;
      waitIdle("frame_timeout");
      checkOutput("frame_beats", 32'(beats_seen), 32'(vecs[idx].exp_beats));
      checkOutput("frame_reqs", 32'(reqs_seen), 32'(vecs[idx].exp_reqs));
      checkOutput("frame_leftover", 32'(exp_q.size() + req_q.size()), 32'd0);
      checkOutput("frame_tvalid_end", 32'(s_axis_vid_tvalid), 32'd0);
      checkOutput("frame_underflow", 32'(underflow), 32'd0);
   endtask

   task automatic doReset();
      reset             = 1'b1;
      rd_ack            = 1'b0;
      rd_data_valid     = 1'b0;
      s_axis_vid_tready = 1'b0;
      @(posedge m_axis_vid_aclk);
      #1;
      reset = 1'b0;
      exp_q.delete();
      req_q.delete();
      mem_q.delete();
      prev_stall = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] cap_addr;
      bit          stable_ok;
      int          n;

      vecs[0] = '{12'd4,  12'd2, 32'h0000_1000, 16'h0040, 0, 8,  2};
      vecs[1] = '{12'd20, 12'd2, 32'h0000_2000, 16'h0100, 0, 40, 6};
      vecs[2] = '{12'd4,  12'd2, 32'h0000_1000, 16'h0040, 1, 8,  2};
      vecs[3] = '{12'd1,  12'd1, 32'h0000_3000, 16'h0004, 0, 1,  1};
      vecs[4] = '{12'd8,  12'd3, 32'hFFFF_FFC0, 16'h0020, 0, 24, 3};
      vecs[5] = '{12'd20, 12'd3, 32'h0000_4000, 16'h0050, 1, 60, 9};

      reset = 1'b1; enable = 1'b0; rd_ack = 1'b0; rd_data_valid = 1'b0; rd_data = 32'd0;
      s_axis_vid_tready = 1'b0; cfg_base = 32'd0; cfg_pitch = 16'd0; cfg_width = 12'd0; cfg_height = 12'd0;
      ack_en = 1'b1; mem_en = 1'b1; tog = 1'b1; prev_stall = 1'b0; tready_mode = 0;
      beats_seen = 0; reqs_seen = 0; beats_delivered = 0;

      @(posedge m_axis_vid_aclk);
      #1;
      checkOutput("rst_rd_req", 32'(rd_req), 32'd0);
      checkOutput("rst_rd_addr", rd_addr, 32'd0);
      checkOutput("rst_rd_len", 32'(rd_len), 32'd0);
      checkOutput("rst_tvalid", 32'(s_axis_vid_tvalid), 32'd0);
      checkOutput("rst_tuser", 32'(s_axis_vid_tuser), 32'd0);
      checkOutput("rst_tlast", 32'(s_axis_vid_tlast), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_underflow", 32'(underflow), 32'd0);
      reset = 1'b0;
      @(posedge m_axis_vid_aclk);
      #1;
      checkOutput("post_rst_busy", 32'(busy), 32'd0);
      checkOutput("post_rst_tvalid", 32'(s_axis_vid_tvalid), 32'd0);

      for (int i = 0; i < 6; i++) runFrame(i);
      tready_mode = 0;

      // Zero-sized frames never start.
      cfg_width = 12'd0; cfg_height = 12'd2; enable = 1'b1;
      for (int i = 0; i < 5; i++) applyStimulus();
      checkOutput("zero_width_busy", 32'(busy), 32'd0);
      checkOutput("zero_width_req", 32'(rd_req), 32'd0);
      cfg_width = 12'd4; cfg_height = 12'd0;
      for (int i = 0; i < 5; i++) applyStimulus();
      checkOutput("zero_height_busy", 32'(busy), 32'd0);
      enable = 1'b0;
      applyStimulus();

      // Enable dropped on beat 2: the frame still completes, then the block idles.
      startFrame(12'd4, 12'd2, 32'h0000_1000, 16'h0040);
      enable = 1'b1;
      n = 0;
      while (beats_seen < 3 && n < 200) begin applyStimulus(); n++; end
      enable = 1'b0;
      waitIdle("endrop_timeout");
      checkOutput("endrop_beats", 32'(beats_seen), 32'd8);
      checkOutput("endrop_leftover", 32'(exp_q.size()), 32'd0);
      for (int i = 0; i < 10; i++) applyStimulus();
      checkOutput("endrop_busy", 32'(busy), 32'd0);
      checkOutput("endrop_reqs", 32'(reqs_seen), 32'd2);

      // Memory stalled mid-line: request held, FIFO drains, underflow flagged.
      startFrame(12'd20, 12'd2, 32'h0000_8000, 16'h0040);
      enable = 1'b1;
      applyStimulus();
      enable = 1'b0;
      n = 0;
      while (beats_seen < 1 && n < 200) begin applyStimulus(); n++; end
      ack_en = 1'b0; mem_en = 1'b0;
      stable_ok = 1'b1;
      cap_addr  = 32'd0;
      for (int i = 0; i < 50; i++) begin
         if (i == 5) cap_addr = rd_addr;
         if (i >= 5 && (rd_req !== 1'b1 || rd_addr !== cap_addr)) stable_ok = 1'b0;
         applyStimulus();
      end
      checkOutput("stall_req_held", 32'(stable_ok), 32'd1);
      checkOutput("stall_tvalid", 32'(s_axis_vid_tvalid), 32'd0);
      checkOutput("stall_underflow", 32'(underflow), 32'd1);
      ack_en = 1'b1; mem_en = 1'b1;
      waitIdle("stall_timeout");
      checkOutput("stall_beats", 32'(beats_seen), 32'd40);
      checkOutput("stall_leftover", 32'(exp_q.size()), 32'd0);
      checkOutput("underflow_sticky", 32'(underflow), 32'd1);
      doReset();
      checkOutput("underflow_cleared", 32'(underflow), 32'd0);

      // Reset mid-line with 5 pixels buffered, then a stray beat, then a clean frame.
      tready_mode = 2;
      startFrame(12'd20, 12'd2, 32'h0000_9000, 16'h0040);
      enable = 1'b1;
      applyStimulus();
      enable = 1'b0;
      n = 0;
      while (beats_delivered < 5 && n < 200) begin applyStimulus(); n++; end
      mem_en = 1'b0;
      checkOutput("pre_reset_tvalid", 32'(s_axis_vid_tvalid), 32'd1);
      doReset();
      checkOutput("midrst_tvalid", 32'(s_axis_vid_tvalid), 32'd0);
      checkOutput("midrst_rd_req", 32'(rd_req), 32'd0);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      rd_data_valid = 1'b1;
      rd_data       = 32'hDEAD_BEEF;
      @(posedge m_axis_vid_aclk);
      #1;
      rd_data_valid = 1'b0;
      @(posedge m_axis_vid_aclk);
      #1;
      checkOutput("stray_data_ignored", 32'(s_axis_vid_tvalid), 32'd0);
      mem_en = 1'b1;
      runFrame(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
